// File: rtl/uart_tx_source_switch_pkg.sv
// Shared types and constants for the frame-aware TXD source switch.
package uart_tx_source_switch_pkg;

   // 12 MHz HSOSC / 115200 baud
   localparam int DEFAULT_BAUD_PERIOD = 104;

   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_OCD = 1'b1;

   typedef enum logic [1:0] {
      ST_PASS  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

endpackage

// File: rtl/uart_tx_source_switch_line_idle_detector.sv
// Saturating count of consecutive high samples on a UART line; idle_full marks
// a full frame-length of idle.
module uart_line_idle_detector #(
   parameter int IDLE_CYCLES = 1040
) (
   input  logic clk,
   input  logic reset,
   input  logic line,
   input  logic clear,
   output logic idle_full
);

   localparam int CW = $clog2(IDLE_CYCLES + 1);
   localparam logic [CW-1:0] FULL = CW'(IDLE_CYCLES);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || !line) begin
         count <= '0;
      end else if (count != FULL) begin
         count <= count + 1'b1;
      end
   end

   assign idle_full = (count == FULL);

endmodule

// File: rtl/uart_tx_source_switch.sv
// 2:1 TXD arbiter between CPU and OCD UART streams; the source changes only
// after the line has been idle for a whole frame, so no byte is cut or spliced.
//
// state    | meaning
// PASS     | granted source copied to TXD with one cycle of latency
// DRAIN    | change requested, waiting for a frame-length idle on the current source
// BLANK    | new source granted, TXD held high until that source proves idle
module uart_tx_source_switch
   import uart_tx_source_switch_pkg::*;
#(
   parameter int   BAUD_PERIOD = DEFAULT_BAUD_PERIOD,
   parameter int   IDLE_BITS   = 10,
   parameter logic INIT_SRC    = SRC_CPU
) (
   input  logic clk,
   input  logic reset,
   input  logic sel_ocd1_cpu0,
   input  logic tx_cpu,
   input  logic tx_ocd,
   output logic TXD,
   output logic active_src,
   output logic switch_pending,
   output logic blanked
);

   localparam int IDLE_CYCLES = IDLE_BITS * BAUD_PERIOD;

   state_t state, state_n;
   logic   active_n;
   logic   txd_q, txd_n;
   logic   blanked_q, blanked_n;
   logic   cur_tx;
   logic   req;
   logic   clear;
   logic   idle_full;

   assign cur_tx = (active_src == SRC_OCD) ? tx_ocd : tx_cpu;
   assign req    = (sel_ocd1_cpu0 != active_src);

   uart_line_idle_detector #(
      .IDLE_CYCLES(IDLE_CYCLES)
   ) u_idle (
      .clk      (clk),
      .reset    (reset),
      .line     (cur_tx),
      .clear    (clear),
      .idle_full(idle_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_BLANK;
         active_src <= INIT_SRC;
         txd_q      <= 1'b1;
         blanked_q  <= 1'b1;
      end else begin
         state      <= state_n;
         active_src <= active_n;
         txd_q      <= txd_n;
         blanked_q  <= blanked_n;
      end
   end

   always_comb begin
      state_n   = state;
      active_n  = active_src;
      blanked_n = blanked_q;
      txd_n     = blanked_q ? 1'b1 : cur_tx;
      clear     = 1'b0;
      case (state)
         ST_PASS: begin
            blanked_n = 1'b0;
            txd_n     = cur_tx;
            if (req) state_n = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A blanked drain (entered from BLANK) must not expose an unproven source
            if (!req) begin
               state_n = blanked_q ? ST_BLANK : ST_PASS;
            end else if (idle_full) begin
               active_n  = ~active_src;
               clear     = 1'b1;
               state_n   = ST_BLANK;
               blanked_n = 1'b1;
               txd_n     = 1'b1;
            end
         end
         ST_BLANK: begin
            txd_n     = 1'b1;
            blanked_n = 1'b1;
            if (req) begin
               state_n = ST_DRAIN;
            end else if (idle_full) begin
               state_n   = ST_PASS;
               blanked_n = 1'b0;
            end
         end
         default: begin
            state_n   = ST_BLANK;
            blanked_n = 1'b1;
            txd_n     = 1'b1;
         end
      endcase
   end

   assign TXD            = txd_q;
   assign blanked        = blanked_q;
   assign switch_pending = req;

endmodule
